// File: rtl/pipe_stage_hold_buf.sv
// Pipeline stage register with a DEPTH-entry hold buffer: bubbles or freezes on HOLD,
// buffers incoming words, replays them in FIFO order once HOLD drops.
module pipe_stage_hold_buf #(
  parameter int unsigned     W         = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [W-1:0]    BUBBLE    = '0,
  parameter bit              HOLD_MODE = 1'b0,
  localparam int unsigned    CW        = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [W-1:0]  D_IN,
  input  logic          IN_VALID,
  input  logic          HOLD,
  input  logic          FLUSH,
  output logic [W-1:0]  Q,
  output logic          Q_VALID,
  output logic          STALL_UP,
  output logic [CW-1:0] COUNT,
  output logic          OVERFLOW
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty, push, pop, drop;

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (COUNT == CW'(DEPTH));
  assign empty    = (COUNT == '0);
  assign STALL_UP = HOLD && full;

  // While draining, a valid input must queue behind buffered words; a simultaneous
  // pop frees the slot, so a push at full is legal only when HOLD is low.
  assign push = !FLUSH && IN_VALID && (HOLD ? !full : !empty);
  assign pop  = !FLUSH && !HOLD && !empty;
  assign drop = !FLUSH && HOLD && IN_VALID && full;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= D_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q        <= BUBBLE;
      Q_VALID  <= 1'b0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
    end else if (FLUSH) begin
      Q       <= BUBBLE;
      Q_VALID <= 1'b0;
      COUNT   <= '0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (drop) OVERFLOW <= 1'b1;
      case ({push, pop})
        2'b10:   COUNT <= COUNT + CW'(1);
        2'b01:   COUNT <= COUNT - CW'(1);
        default: COUNT <= COUNT;
      endcase
      if (HOLD) begin
        if (!HOLD_MODE) begin
          Q       <= BUBBLE;
          Q_VALID <= 1'b0;
        end
      end else if (pop) begin
        Q       <= mem[rptr];
        Q_VALID <= 1'b1;
      end else if (IN_VALID) begin
        Q       <= D_IN;
        Q_VALID <= 1'b1;
      end else begin
        Q       <= BUBBLE;
        Q_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_hold_buf.sv
// Directed bench: table-driven vectors on a DEPTH=4 bubble-mode stage, hand-written
// sequences on a DEPTH=3 freeze-mode stage for freeze, wrap and push+pop at full.
module tb_pipe_stage_hold_buf;

  localparam logic [31:0] BUB1 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n, iv, hold, flush;
  logic [31:0] d;
  logic [31:0] q0, q1;
  logic        qv0, qv1, st0, st1, ov0, ov1;
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_hold_buf #(.W(32), .DEPTH(4), .BUBBLE(32'h0), .HOLD_MODE(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d), .IN_VALID(iv), .HOLD(hold), .FLUSH(flush),
    .Q(q0), .Q_VALID(qv0), .STALL_UP(st0), .COUNT(cnt0), .OVERFLOW(ov0));

  pipe_stage_hold_buf #(.W(32), .DEPTH(3), .BUBBLE(BUB1), .HOLD_MODE(1'b1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d), .IN_VALID(iv), .HOLD(hold), .FLUSH(flush),
    .Q(q1), .Q_VALID(qv1), .STALL_UP(st1), .COUNT(cnt1), .OVERFLOW(ov1));

  typedef struct {
    logic        rst_n;
    logic [31:0] d;
    logic        iv, hold, flush;
    logic        stall;   // expected before the edge
    logic [31:0] q;
    logic        qv;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [31:0] dd, logic v, logic h, logic f,
                              logic s, logic [31:0] eq, logic eqv, logic [2:0] ec, logic eo);
    vec_t x;
    x.rst_n = r; x.d = dd; x.iv = v; x.hold = h; x.flush = f;
    x.stall = s; x.q = eq; x.qv = eqv; x.cnt = ec; x.ovf = eo;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies one cycle of stimulus to both instances and checks the selected one.
  task automatic step(input int sel, input string tag, input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; d = v.d; iv = v.iv; hold = v.hold; flush = v.flush;
    #1;
    chk({tag, ".stall"}, {31'b0, sel == 0 ? st0 : st1}, {31'b0, v.stall});
    @(posedge clk);
    #1;
    if (sel == 0) begin
      chk({tag, ".q"},     q0,          v.q);
      chk({tag, ".qv"},    {31'b0, qv0}, {31'b0, v.qv});
      chk({tag, ".count"}, {29'b0, cnt0}, {29'b0, v.cnt});
      chk({tag, ".ovf"},   {31'b0, ov0}, {31'b0, v.ovf});
    end else begin
      chk({tag, ".q"},     q1,          v.q);
      chk({tag, ".qv"},    {31'b0, qv1}, {31'b0, v.qv});
      chk({tag, ".count"}, {30'b0, cnt1}, {29'b0, v.cnt});
      chk({tag, ".ovf"},   {31'b0, ov1}, {31'b0, v.ovf});
    end
  endtask

  initial begin
    rst_n = 1'b0; d = '0; iv = 1'b0; hold = 1'b0; flush = 1'b0;

    //               rst d            iv hold fl  stall q            qv cnt ovf
    tbl.push_back(mk(0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 0)); // reset
    // pass-through
    tbl.push_back(mk(1, 32'hA1,       1, 0, 0,  0, 32'hA1,       1, 0, 0));
    tbl.push_back(mk(1, 32'hA2,       1, 0, 0,  0, 32'hA2,       1, 0, 0));
    tbl.push_back(mk(1, 32'hA3,       1, 0, 0,  0, 32'hA3,       1, 0, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 0));
    // hold and replay
    tbl.push_back(mk(1, 32'hB1,       1, 1, 0,  0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 32'hB2,       1, 1, 0,  0, 32'h0,        0, 2, 0));
    tbl.push_back(mk(1, 32'hB3,       1, 1, 0,  0, 32'h0,        0, 3, 0));
    tbl.push_back(mk(1, 32'hB4,       1, 0, 0,  0, 32'hB1,       1, 3, 0));
    tbl.push_back(mk(1, 32'hB5,       1, 0, 0,  0, 32'hB2,       1, 3, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hB3,       1, 2, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hB4,       1, 1, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hB5,       1, 0, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 0));
    // overflow
    tbl.push_back(mk(1, 32'hC1,       1, 1, 0,  0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 32'hC2,       1, 1, 0,  0, 32'h0,        0, 2, 0));
    tbl.push_back(mk(1, 32'hC3,       1, 1, 0,  0, 32'h0,        0, 3, 0));
    tbl.push_back(mk(1, 32'hC4,       1, 1, 0,  0, 32'h0,        0, 4, 0));
    tbl.push_back(mk(1, 32'hC5,       1, 1, 0,  1, 32'h0,        0, 4, 1));
    tbl.push_back(mk(1, 32'hC6,       1, 1, 0,  1, 32'h0,        0, 4, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hC1,       1, 3, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hC2,       1, 2, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hC3,       1, 1, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'hC4,       1, 0, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 1));
    // flush beats hold, no replay afterwards
    tbl.push_back(mk(1, 32'h61,       1, 1, 0,  0, 32'h0,        0, 1, 1));
    tbl.push_back(mk(1, 32'h62,       1, 1, 0,  0, 32'h0,        0, 2, 1));
    tbl.push_back(mk(1, 32'h63,       1, 1, 1,  0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 1));
    // reset mid-drain, then 1-cycle pass-through
    tbl.push_back(mk(1, 32'h71,       1, 1, 0,  0, 32'h0,        0, 1, 1));
    tbl.push_back(mk(1, 32'h72,       1, 1, 0,  0, 32'h0,        0, 2, 1));
    tbl.push_back(mk(1, 32'h73,       1, 1, 0,  0, 32'h0,        0, 3, 1));
    tbl.push_back(mk(1, 32'h74,       1, 0, 0,  0, 32'h71,       1, 3, 1));
    tbl.push_back(mk(0, 32'h75,       1, 0, 0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 32'hF1,       1, 0, 0,  0, 32'hF1,       1, 0, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 0));

    foreach (tbl[i]) step(0, $sformatf("v%0d", i), tbl[i]);

    // Freeze mode, DEPTH=3, non-zero bubble.
    step(1, "fz.rst",  mk(0, 32'h0,  0, 0, 0, 0, BUB1,  0, 0, 0));
    step(1, "fz.d7",   mk(1, 32'hD7, 1, 0, 0, 0, 32'hD7, 1, 0, 0));
    step(1, "fz.e1",   mk(1, 32'hE1, 1, 1, 0, 0, 32'hD7, 1, 1, 0));
    step(1, "fz.e2",   mk(1, 32'hE2, 1, 1, 0, 0, 32'hD7, 1, 2, 0));
    step(1, "fz.r1",   mk(1, 32'h0,  0, 0, 0, 0, 32'hE1, 1, 1, 0));
    step(1, "fz.r2",   mk(1, 32'h0,  0, 0, 0, 0, 32'hE2, 1, 0, 0));
    step(1, "fz.idle", mk(1, 32'h0,  0, 0, 0, 0, BUB1,  0, 0, 0));
    // Pointers now at 2: fill wraps 2->0->1, then push+pop at full.
    step(1, "wr.e3",   mk(1, 32'hE3, 1, 1, 0, 0, BUB1,  0, 1, 0));
    step(1, "wr.e4",   mk(1, 32'hE4, 1, 1, 0, 0, BUB1,  0, 2, 0));
    step(1, "wr.e5",   mk(1, 32'hE5, 1, 1, 0, 0, BUB1,  0, 3, 0));
    step(1, "wr.e6",   mk(1, 32'hE6, 1, 1, 0, 1, BUB1,  0, 3, 1));
    step(1, "wr.e7",   mk(1, 32'hE7, 1, 0, 0, 0, 32'hE3, 1, 3, 1));
    step(1, "wr.p1",   mk(1, 32'h0,  0, 0, 0, 0, 32'hE4, 1, 2, 1));
    step(1, "wr.p2",   mk(1, 32'h0,  0, 0, 0, 0, 32'hE5, 1, 1, 1));
    step(1, "wr.p3",   mk(1, 32'h0,  0, 0, 0, 0, 32'hE7, 1, 0, 1));
    step(1, "wr.idle", mk(1, 32'h0,  0, 0, 0, 0, BUB1,  0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hold_buf.md
Name: pipe_stage_hold_buf

Overview:
- Parametrised pipeline stage register between two processor pipeline stages; carries one W-bit control/data bundle per cycle.
- On HOLD it inserts a bubble (or freezes its output) and buffers up to DEPTH incoming words instead of a single one.
- When HOLD is released, buffered words are replayed in order, then the stage returns to pass-through.
- Adds FLUSH, a full indication to upstream, and a sticky overflow flag.

Parameters:
- W, 32, bundle width (ALU/SH/M/T/C/address fields packed by the instantiating design).
- DEPTH, 4, hold-buffer entries (≥1).
- BUBBLE, 32'h0 (W bits), NOP word driven on Q during a bubble; the instantiating design overrides it with its NOP encoding.
- HOLD_MODE, 0, 0 = insert BUBBLE during HOLD; 1 = freeze Q/Q_VALID during HOLD.
- Localparam CW = $clog2(DEPTH+1), width of COUNT.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset.
- D_IN  input  W  bundle from the previous stage.
- IN_VALID  input  1  D_IN holds a real word.
- HOLD  input  1  hold the next stage.
- FLUSH  input  1  discard the buffer and in-flight output.
- Q  output  W  bundle to the next stage (registered).
- Q_VALID  output  1  Q holds a real word (registered).
- STALL_UP  output  1  combinational: HOLD && COUNT==DEPTH.
- COUNT  output  CW  buffered-word count (registered).
- OVERFLOW  output  1  sticky: a word was dropped.

Behaviour:
- Reset is synchronous, sampled on CLK rising edge with RST_N=0.
  - Q=BUBBLE, Q_VALID=0, COUNT=0, OVERFLOW=0.
  - Buffer read/write pointers are cleared to 0.
- Priority per edge: reset > FLUSH > HOLD > normal.
- FLUSH=1:
  - Q=BUBBLE, Q_VALID=0, COUNT=0, pointers cleared.
  - D_IN is discarded and OVERFLOW is kept.
  - FLUSH overrides HOLD in the same cycle.
- HOLD=1, no FLUSH:
  - HOLD_MODE=0: Q=BUBBLE, Q_VALID=0.
  - HOLD_MODE=1: Q and Q_VALID keep their values.
  - IN_VALID=1 and COUNT<DEPTH: D_IN is written at the write pointer and COUNT increments.
  - IN_VALID=1 and COUNT==DEPTH: D_IN is dropped, OVERFLOW is set to 1, COUNT is unchanged.
  - IN_VALID=0: the buffer is unchanged.
- HOLD=0, no FLUSH, COUNT>0 (drain):
  - Q=buffer head, Q_VALID=1, the entry is popped.
  - If IN_VALID=1 in the same cycle, D_IN is pushed to the tail, so push and pop happen together.
  - COUNT: net unchanged with push+pop, decrements with pop only.
  - Push+pop is legal at COUNT==DEPTH.
  - Order is strictly FIFO; D_IN never bypasses buffered words.
- HOLD=0, no FLUSH, COUNT==0 (pass-through):
  - IN_VALID=1: Q=D_IN, Q_VALID=1.
  - IN_VALID=0: Q=BUBBLE, Q_VALID=0.
  - Latency is 1 cycle.
- Pointers are modulo DEPTH and wrap; non-power-of-2 DEPTH must wrap explicitly at DEPTH-1→0.
- HOLD toggling mid-drain: draining pauses and the HOLD rules apply; the remaining entries keep their order.
- Reset asserted mid-hold or mid-drain: all buffered words are lost, with the reset values above.
- OVERFLOW clears only on reset.
- COUNT never exceeds DEPTH.

Test Plan:
1. Pass-through, DEPTH=4, HOLD_MODE=0: D_IN=A1,A2,A3 with IN_VALID=1 on consecutive cycles → Q=A1,A2,A3 one cycle later each, Q_VALID=1, COUNT=0.
2. Hold and replay: HOLD=1 for 3 cycles with B1,B2,B3 valid, then HOLD=0 with B4,B5 valid.
   - During hold: Q=BUBBLE, Q_VALID=0, COUNT=1,2,3.
   - After release: Q=B1,B2,B3,B4,B5 on consecutive cycles.
   - COUNT goes 3,3,2,1,0 (push+pop while B4/B5 arrive, then pop only).
3. Overflow: HOLD=1 for 6 cycles with valid C1..C6, DEPTH=4.
   - COUNT saturates at 4 and STALL_UP=1 from the 5th cycle.
   - OVERFLOW=1 after C5 is dropped.
   - Release replays C1..C4 only.
   - OVERFLOW stays 1 until RST_N=0.
4. Flush priority: 2 words buffered, then FLUSH=1 and HOLD=1 in the same cycle → next edge Q=BUBBLE, Q_VALID=0, COUNT=0; after release, no replay.
5. Freeze mode, HOLD_MODE=1: Q=D7, Q_VALID=1, then HOLD=1 for 2 cycles with E1,E2 → Q stays D7/valid; after release Q=E1,E2.
6. Reset mid-drain: COUNT=3 during drain, RST_N=0 for one edge → Q=BUBBLE, Q_VALID=0, COUNT=0, OVERFLOW=0; the next valid F1 passes through with 1-cycle latency.
